// File: rtl/fpga_wb_regs_pkg.sv
// ---------------------------------------------------------------------------
// fpga_wb_regs_pkg
//   Shared constants for the AL4S3B fabric control register bank:
//   register byte offsets, channel field widths, the pulse counter width
//   and a byte-offset to word-address helper.
//   Optional feature macro used by the register bank: FPGA_WB_REGS_TIMESTAMP_EN
// ---------------------------------------------------------------------------
package fpga_wb_regs_pkg;

    // Register byte offsets as seen by software.
    localparam logic [31:0] OFF_ID       = 32'h000;
    localparam logic [31:0] OFF_REV      = 32'h004;
    localparam logic [31:0] OFF_FIFO_RST = 32'h008;
    localparam logic [31:0] OFF_CH_EN    = 32'h00C;
    localparam logic [31:0] OFF_OVERRUN  = 32'h010;
    localparam logic [31:0] OFF_IRQ_MASK = 32'h014;
    localparam logic [31:0] OFF_SCRATCH  = 32'h018;
    localparam logic [31:0] OFF_TS       = 32'h01C;

    // Upper bound of the per-channel fields (enable/reset/overrun/mask).
    localparam int unsigned MAX_CH     = 16;
    localparam int unsigned FIFO_RST_W = MAX_CH;
    localparam int unsigned OVERRUN_W  = MAX_CH;

    // FIFO reset pulse counter width (pulse length 1..255).
    localparam int unsigned PULSE_CNT_W = 8;

    // Wishbone address bus carries word addresses.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_off);
        return byte_off >> 2;
    endfunction

endpackage

// File: rtl/fpga_rst_pulse_gen.sv
// ---------------------------------------------------------------------------
// fpga_rst_pulse_gen
//   Self-timed reset pulse for one channel. A load sets the down-counter to
//   RST_PULSE_CYC; busy_o is high while the counter is nonzero. Loading while
//   busy restarts the count, stretching the pulse.
// Ports:
//   clk     in   clock
//   rst     in   asynchronous reset, active-high
//   load_i  in   (re)start the pulse
//   busy_o  out  pulse output / busy flag
// ---------------------------------------------------------------------------
module fpga_rst_pulse_gen
    import fpga_wb_regs_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic busy_o
);

    localparam logic [PULSE_CNT_W-1:0] CNT_LOAD = PULSE_CNT_W'(RST_PULSE_CYC);
    localparam logic [PULSE_CNT_W-1:0] CNT_ONE  = PULSE_CNT_W'(1);

    logic [PULSE_CNT_W-1:0] cnt_q;
    logic [PULSE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/fpga_wb_ctrl_regs.sv
// ---------------------------------------------------------------------------
// fpga_wb_ctrl_regs
//   Wishbone slave register bank for the AL4S3B FPGA fabric: device ID and
//   revision, per-channel enables, self-timed FIFO reset pulses, sticky W1C
//   overrun flags, interrupt mask, scratch register and an optional
//   free-running timestamp.
//   Optional feature macro: FPGA_WB_REGS_TIMESTAMP_EN (timestamp at 0x01C;
//   when undefined 0x01C reads as unmapped).
// Ports:
//   WBs_CLK_i       in   fabric / Wishbone clock
//   WBs_RST_i       in   asynchronous reset, active-high
//   WBs_ADR_i       in   word address (byte offset >> 2)
//   WBs_CYC_i       in   cycle
//   WBs_STB_i       in   strobe
//   WBs_WE_i        in   write enable
//   WBs_BYTE_STB_i  in   byte lane enables
//   WBs_DAT_i       in   write data
//   WBs_DAT_o       out  registered read data
//   WBs_ACK_o       out  transfer acknowledge (one cycle)
//   ovr_evt_i       in   per-channel overrun event, level sampled each clock
//   ch_en_o         out  per-channel enable
//   fifo_rst_o      out  per-channel FIFO reset pulse
//   irq_o           out  registered OR of (overrun & mask)
// ---------------------------------------------------------------------------
module fpga_wb_ctrl_regs
    import fpga_wb_regs_pkg::*;
#(
    parameter int unsigned ADDRWIDTH     = 10,
    parameter int unsigned DATAWIDTH     = 32,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned RST_PULSE_CYC = 4,
    parameter logic [31:0] DEVICE_ID     = 32'h0ADC0002,
    parameter logic [31:0] REV_NUM       = 32'h00000200,
    parameter logic [31:0] DEF_REG_VALUE = 32'hFABDEFAC
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
    input  logic                 WBs_CYC_i,
    input  logic                 WBs_STB_i,
    input  logic                 WBs_WE_i,
    input  logic [3:0]           WBs_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0] WBs_DAT_i,
    output logic [DATAWIDTH-1:0] WBs_DAT_o,
    output logic                 WBs_ACK_o,
    input  logic [NUM_CH-1:0]    ovr_evt_i,
    output logic [NUM_CH-1:0]    ch_en_o,
    output logic [NUM_CH-1:0]    fifo_rst_o,
    output logic                 irq_o
);

    localparam logic [31:0] A_ID       = word_addr(OFF_ID);
    localparam logic [31:0] A_REV      = word_addr(OFF_REV);
    localparam logic [31:0] A_FIFO_RST = word_addr(OFF_FIFO_RST);
    localparam logic [31:0] A_CH_EN    = word_addr(OFF_CH_EN);
    localparam logic [31:0] A_OVERRUN  = word_addr(OFF_OVERRUN);
    localparam logic [31:0] A_IRQ_MASK = word_addr(OFF_IRQ_MASK);
    localparam logic [31:0] A_SCRATCH  = word_addr(OFF_SCRATCH);
`ifdef FPGA_WB_REGS_TIMESTAMP_EN
    localparam logic [31:0] A_TS       = word_addr(OFF_TS);
`endif

    // Handshake: a transfer is accepted on the first clock edge where
    // CYC & STB are high and ACK is low. ACK is then high for exactly one
    // cycle (one wait state); read data and write side effects land on the
    // accepting edge. A master that drops CYC or STB before that edge causes
    // nothing to happen.
    logic        access;
    logic        wr_en;
    logic [31:0] adr_w;
    logic [31:0] byte_mask;
    logic [31:0] rd_data;

    logic              ack_q,     ack_d;
    logic [31:0]       dat_q,     dat_d;
    logic [NUM_CH-1:0] ch_en_q,   ch_en_d;
    logic [NUM_CH-1:0] ovr_q,     ovr_d;
    logic [NUM_CH-1:0] mask_q,    mask_d;
    logic [31:0]       scratch_q, scratch_d;
    logic              irq_q,     irq_d;
    logic [NUM_CH-1:0] pulse_load;
    logic [NUM_CH-1:0] pulse_busy;
`ifdef FPGA_WB_REGS_TIMESTAMP_EN
    logic [31:0]       ts_q,      ts_d;
`endif

    assign access    = WBs_CYC_i & WBs_STB_i & ~ack_q;
    assign wr_en     = access & WBs_WE_i;
    assign adr_w     = 32'(WBs_ADR_i);
    assign byte_mask = {{8{WBs_BYTE_STB_i[3]}}, {8{WBs_BYTE_STB_i[2]}},
                        {8{WBs_BYTE_STB_i[1]}}, {8{WBs_BYTE_STB_i[0]}}};

    // Read multiplexer; channel fields are zero-extended.
    always_comb begin
        rd_data = DEF_REG_VALUE;
        case (adr_w)
            A_ID:       rd_data = DEVICE_ID;
            A_REV:      rd_data = REV_NUM;
            A_FIFO_RST: rd_data = 32'(pulse_busy);
            A_CH_EN:    rd_data = 32'(ch_en_q);
            A_OVERRUN:  rd_data = 32'(ovr_q);
            A_IRQ_MASK: rd_data = 32'(mask_q);
            A_SCRATCH:  rd_data = scratch_q;
`ifdef FPGA_WB_REGS_TIMESTAMP_EN
            A_TS:       rd_data = ts_q;
`endif
            default:    rd_data = DEF_REG_VALUE;
        endcase
    end

    always_comb begin
        ack_d      = access;
        dat_d      = access ? rd_data : dat_q;
        ch_en_d    = ch_en_q;
        ovr_d      = ovr_q;
        mask_d     = mask_q;
        scratch_d  = scratch_q;
        pulse_load = '0;

        if (wr_en) begin
            case (adr_w)
                A_FIFO_RST: pulse_load = WBs_DAT_i[NUM_CH-1:0] & byte_mask[NUM_CH-1:0];
                A_CH_EN:    ch_en_d = (ch_en_q & ~byte_mask[NUM_CH-1:0]) |
                                      (WBs_DAT_i[NUM_CH-1:0] & byte_mask[NUM_CH-1:0]);
                A_OVERRUN:  ovr_d = ovr_q & ~(WBs_DAT_i[NUM_CH-1:0] & byte_mask[NUM_CH-1:0]);
                A_IRQ_MASK: mask_d = (mask_q & ~byte_mask[NUM_CH-1:0]) |
                                     (WBs_DAT_i[NUM_CH-1:0] & byte_mask[NUM_CH-1:0]);
                A_SCRATCH:  scratch_d = (scratch_q & ~byte_mask) | (WBs_DAT_i & byte_mask);
                default:    ;
            endcase
        end

        // Applied after the W1C so a coincident event keeps the flag set.
        ovr_d = ovr_d | ovr_evt_i;

        irq_d = |(ovr_q & mask_q);
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            ch_en_q   <= '0;
            ovr_q     <= '0;
            mask_q    <= '0;
            scratch_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            ch_en_q   <= ch_en_d;
            ovr_q     <= ovr_d;
            mask_q    <= mask_d;
            scratch_q <= scratch_d;
            irq_q     <= irq_d;
        end
    end

`ifdef FPGA_WB_REGS_TIMESTAMP_EN
    // Free-running; any write to its offset restarts it from zero.
    always_comb begin
        ts_d = ts_q + 32'd1;
        if (wr_en && (adr_w == A_TS)) begin
            ts_d = '0;
        end
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end
`endif

    for (genvar n = 0; n < NUM_CH; n++) begin : g_pulse
        fpga_rst_pulse_gen #(
            .RST_PULSE_CYC(RST_PULSE_CYC)
        ) u_pulse (
            .clk   (WBs_CLK_i),
            .rst   (WBs_RST_i),
            .load_i(pulse_load[n]),
            .busy_o(pulse_busy[n])
        );
    end

    assign WBs_ACK_o  = ack_q;
    assign WBs_DAT_o  = dat_q;
    assign ch_en_o    = ch_en_q;
    assign fifo_rst_o = pulse_busy;
    assign irq_o      = irq_q;

endmodule
